// File: rtl/frontend_issue_ctrl_pkg.sv
// Shared types and selector action codes for the frontend issue controller.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package frontend_issue_ctrl_pkg;

    // one fetched instruction together with the address it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } fe_state_t;

    // selector action codes, same encoding as the selector's Common.vh
    localparam logic [1:0] INSERT_NOP = 2'd0;
    localparam logic [1:0] POP_DATA   = 2'd1;
    localparam logic [1:0] POP_BUF    = 2'd2;

    localparam logic [31:0] NOP_WORD = 32'h0;

    function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/frontend_fifo.sv
// Fetch FIFO: DEPTH entries, head and head+1 visible, pop of one or two entries per cycle.
// Latency: push visible at head one cycle after the write; pops take effect at the clock edge.
// Backpressure: none internally; the writer must never push into a full queue.
module frontend_fifo
    import frontend_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_dat,
    input  logic                   pop1,
    input  logic                   pop2,
    output fetch_entry_t           head_dat,
    output fetch_entry_t           head1_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   n_pop;

    // entries leaving this cycle; pop2 removes head and head+1 together
    always_comb begin
        n_pop = '0;
        if (pop2) begin
            n_pop = (AW+1)'(2);
        end else if (pop1) begin
            n_pop = (AW+1)'(1);
        end
    end

    // pointers and occupancy; a flush empties the queue in one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + n_pop[AW-1:0];
            count  <= count + {{AW{1'b0}}, push} - n_pop;
        end
    end

    // storage; slots are only read while counted valid, so no reset is needed
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign head_dat  = mem[rd_ptr];
    assign head1_dat = mem[rd_ptr + AW'(1)];

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        push |-> ((count - n_pop) < DEPTH_W));
    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
        n_pop <= count);
    a_count_range: assert property (@(posedge clk) disable iff (!resetn)
        count <= DEPTH_W);

endmodule

// File: rtl/frontend_issue_ctrl.sv
// Frontend sequencer: fetch PC, fetch FIFO (C slot) and hold buffer (B slot) around the selector; FRONTEND_STATS_EN adds event counters.
// Latency: imem response pushed the cycle it arrives, issue state updates on the fire edge, redirect costs one DISCARD cycle.
// Backpressure: dec_ready low holds both slots; fetch stops once FIFO occupancy plus the in-flight request reaches DEPTH.
module frontend_issue_ctrl
    import frontend_issue_ctrl_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_valid,
    input  logic [31:0]            imem_data,
    output logic [31:0]            sel_cpc,
    output logic [31:0]            sel_data,
    output logic [31:0]            sel_bpc,
    output logic [31:0]            sel_bf,
    input  logic                   sel_req,
    input  logic [1:0]             sel_result,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef FRONTEND_STATS_EN
    ,
    output logic [31:0]            stat_issued,
    output logic [31:0]            stat_swapped,
    output logic [31:0]            stat_nops
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fe_state_t    state_q, state_d;
    logic         fetch_en_q;
    logic         req_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic         b_vld_q, b_vld_d;
    logic [31:0]  bpc_q, bpc_d;
    logic [31:0]  bf_q, bf_d;
    logic [CW:0]  occ;
    logic         push;
    logic         pop1;
    logic         pop2;
    logic         fire;
    fetch_entry_t head;
    fetch_entry_t head1;

    frontend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (redirect),
        .push      (push),
        .push_dat  ('{pc: req_pc_q, instr: imem_data}),
        .pop1      (pop1),
        .pop2      (pop2),
        .head_dat  (head),
        .head1_dat (head1),
        .count     (fifo_count)
    );

    // occupancy as seen by the throttle: queued entries plus the response still on its way
    assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, req_q};
    assign imem_req  = fetch_en_q & (state_q == RUN) & ~redirect & (occ < DEPTH_W);
    assign imem_addr = pc_q;
    assign push      = imem_valid & (state_q == RUN) & ~redirect;

    assign dec_valid = (state_q == RUN)
                     & ((fifo_count != '0) | (b_vld_q & (sel_result == INSERT_NOP)));
    assign fire      = dec_valid & dec_ready & ~redirect;

    // an empty slot presents pc 0 and a nop to the selector
    assign sel_cpc  = (fifo_count != '0) ? head.pc    : 32'h0;
    assign sel_data = (fifo_count != '0) ? head.instr : NOP_WORD;
    assign sel_bpc  = bpc_q;
    assign sel_bf   = bf_q;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect always wins, DISCARD lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = DISCARD;
        end else if (state_q == DISCARD) begin
            state_d = RUN;
        end
    end

    // fetch address, in-flight tracking and the pc tag of the outstanding request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_en_q <= 1'b0;
            req_q      <= 1'b0;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'h0;
        end else begin
            fetch_en_q <= 1'b1;
            req_q      <= imem_req;
            if (redirect) begin
                pc_q <= redirect_pc & ~32'h3;
            end else if (imem_req) begin
                pc_q     <= next_fetch_pc(pc_q);
                req_pc_q <= pc_q;
            end
        end
    end

    // apply the selector action on an issue: FIFO pops and next B-slot contents
    always_comb begin
        pop1    = 1'b0;
        pop2    = 1'b0;
        b_vld_d = b_vld_q;
        bpc_d   = bpc_q;
        bf_d    = bf_q;
        if (fire) begin
            case (sel_result)
                POP_DATA: begin
                    if (!sel_req) begin
                        pop1 = 1'b1;
                    end else if (fifo_count >= CW'(2)) begin
                        pop2    = 1'b1;
                        b_vld_d = 1'b1;
                        bpc_d   = head1.pc;
                        bf_d    = head1.instr;
                    end else begin
                        pop1    = 1'b1;
                        b_vld_d = 1'b0;
                        bpc_d   = 32'h0;
                        bf_d    = NOP_WORD;
                    end
                end
                POP_BUF: begin
                    pop1    = 1'b1;
                    b_vld_d = 1'b1;
                    bpc_d   = head.pc;
                    bf_d    = head.instr;
                end
                INSERT_NOP: begin
                    b_vld_d = 1'b0;
                    bpc_d   = 32'h0;
                    bf_d    = NOP_WORD;
                end
                default: ;
            endcase
        end
    end

    // B-slot register; a redirect empties it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_vld_q <= 1'b0;
            bpc_q   <= 32'h0;
            bf_q    <= NOP_WORD;
        end else if (redirect) begin
            b_vld_q <= 1'b0;
            bpc_q   <= 32'h0;
            bf_q    <= NOP_WORD;
        end else begin
            b_vld_q <= b_vld_d;
            bpc_q   <= bpc_d;
            bf_q    <= bf_d;
        end
    end

`ifdef FRONTEND_STATS_EN
    // issue event counters; free-running across redirects, wrap at 2^32
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_issued  <= 32'h0;
            stat_swapped <= 32'h0;
            stat_nops    <= 32'h0;
        end else begin
            if (fire) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (fire && (sel_result == POP_DATA) && b_vld_q && (bf_q != NOP_WORD)) begin
                stat_swapped <= stat_swapped + 32'd1;
            end
            if (fire && (sel_result == INSERT_NOP)) begin
                stat_nops <= stat_nops + 32'd1;
            end
        end
    end
`endif

endmodule
